// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: opcode values, FSM states and instruction field positions
// shared by the cpu_param core and its register file.
package cpu_param_pkg;

    // Instruction layout: four byte-wide fields, each given by its LSB.
    localparam int FIELD_W = 8;
    localparam int OP_LSB  = 24;
    localparam int RD_LSB  = 16;   // also the branch/jump offset
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 0;    // also the immediate

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_LWD   = 8'h09;
    localparam logic [7:0] OP_LWI   = 8'h0A;
    localparam logic [7:0] OP_SWD   = 8'h0B;
    localparam logic [7:0] OP_SWI   = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == OP_LWD) || (op == OP_LWI);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == OP_SWD) || (op == OP_SWI);
    endfunction

endpackage

// File: rtl/cpu_param_regfile.sv
// cpu_param_regfile: NREG x DATA_W registers, two asynchronous read ports,
// one synchronous write port, asynchronous clear.
module cpu_param_regfile #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int IDX_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr1,
    input  logic [IDX_W-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREG];

    // Register array: cleared by reset, one write per clock.
    // NOTE: every entry is reset, which keeps this in flops rather than a RAM
    // macro; that is required because reset must clear all registers at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads see the array before the edge, so a same-cycle write returns the old value.
    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/cpu_param.sv
// cpu_param: multi-cycle core. ALU and branch instructions finish in RUN in one
// cycle; loads/stores spend at least one cycle in MEM; HALT freezes the core.
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [31:0]       PC,
    input  logic [31:0]       INSTRUCTION,
    input  logic              INSTR_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              HALTED
);

    localparam int         IDX_W       = $clog2(NREG);
    localparam logic [8:0] SHIFT_LIMIT = 9'(DATA_W);

    state_t            state, state_next;
    logic [31:0]       ir, instr, pc_next, pc_plus4, br_target;
    logic [7:0]        opcode, rd_f, rs1_f, rs2_f;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext, wdata;
    logic              we, is_load, is_store, shift_zero;
    logic              unused_fields;

    // While in MEM, decode the copy captured on entry so the memory request
    // stays stable no matter what the fetch bus does.
    assign instr  = (state == ST_MEM) ? ir : INSTRUCTION;
    assign opcode = instr[OP_LSB  +: FIELD_W];
    assign rd_f   = instr[RD_LSB  +: FIELD_W];
    assign rs1_f  = instr[RS1_LSB +: FIELD_W];
    assign rs2_f  = instr[RS2_LSB +: FIELD_W];

    // Register indices use only the low bits; the rest are ignored.
    assign unused_fields = ^{rd_f, rs1_f, rs2_f};

    assign imm_ext    = DATA_W'($signed(rs2_f));
    assign pc_plus4   = PC + 32'd4;
    assign br_target  = pc_plus4 + (32'($signed(rd_f)) << 2);
    assign shift_zero = ({1'b0, rs2_f} >= SHIFT_LIMIT);
    assign is_load    = is_load_op(opcode);
    assign is_store   = is_store_op(opcode);

    cpu_param_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk    (CLK),
        .rst    (RESET),
        .we     (we),
        .waddr  (rd_f[IDX_W-1:0]),
        .wdata  (wdata),
        .raddr1 (rs1_f[IDX_W-1:0]),
        .raddr2 (rs2_f[IDX_W-1:0]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    // Memory strobes come straight from the state, so reset drops them at once.
    assign MEM_READ      = (state == ST_MEM) && is_load;
    assign MEM_WRITE     = (state == ST_MEM) && is_store;
    assign MEM_ADDRESS   = ((opcode == OP_LWD) || (opcode == OP_SWD)) ? rs2_val : imm_ext;
    assign MEM_WRITEDATA = rs1_val;
    assign HALTED        = (state == ST_HALT);

    // Next state, next PC and register write for the current instruction.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        we         = 1'b0;
        wdata      = '0;
        case (state)
            ST_RUN: begin
                if (!INSTR_BUSYWAIT) begin
                    pc_next = pc_plus4;
                    case (opcode)
                        OP_LOADI: begin we = 1'b1; wdata = imm_ext;           end
                        OP_MOV:   begin we = 1'b1; wdata = rs1_val;           end
                        OP_ADD:   begin we = 1'b1; wdata = rs1_val + rs2_val; end
                        OP_SUB:   begin we = 1'b1; wdata = rs1_val - rs2_val; end
                        OP_AND:   begin we = 1'b1; wdata = rs1_val & rs2_val; end
                        OP_OR:    begin we = 1'b1; wdata = rs1_val | rs2_val; end
                        OP_SLL:   begin we = 1'b1; wdata = shift_zero ? '0 : (rs1_val << rs2_f); end
                        OP_SRL:   begin we = 1'b1; wdata = shift_zero ? '0 : (rs1_val >> rs2_f); end
                        OP_J:     pc_next = br_target;
                        OP_BEQ:   if (rs1_val == rs2_val) pc_next = br_target;
                        OP_BNE:   if (rs1_val != rs2_val) pc_next = br_target;
                        OP_LWD, OP_LWI, OP_SWD, OP_SWI: begin
                            pc_next    = PC;
                            state_next = ST_MEM;
                        end
                        OP_HALT: begin
                            pc_next    = PC;
                            state_next = ST_HALT;
                        end
                        default: ;   // unknown opcode: plain PC+4
                    endcase
                end
            end
            ST_MEM: begin
                if (!MEM_BUSYWAIT) begin
                    we         = is_load;
                    wdata      = MEM_READDATA;
                    pc_next    = pc_plus4;
                    state_next = ST_RUN;
                end
            end
            ST_HALT: ;
            default: state_next = ST_RUN;
        endcase
    end

    // State, PC and captured instruction registers.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_RUN;
            PC    <= '0;
            ir    <= '0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            if (state == ST_RUN) begin
                ir <= INSTRUCTION;
            end
        end
    end

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: directed scenarios plus a random instruction stream checked
// against an instruction-level model of the core (DATA_W=8, NREG=8), and a
// second DATA_W=16 instance for width-dependent behaviour.
module tb_cpu_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, instruction;
    logic        instr_busywait, mem_read, mem_write, mem_busywait, halted;
    logic [7:0]  mem_address, mem_writedata, mem_readdata;

    logic [31:0] w_pc, w_instruction;
    logic        w_ibusy, w_mrd, w_mwr, w_mbusy, w_halted;
    logic [15:0] w_addr, w_wdata, w_rdata;

    int          n_vec = 0;
    int          n_err = 0;

    // Architectural model state.
    logic [31:0] m_pc;
    logic [7:0]  m_reg [8];

    always #5 clk = ~clk;

    cpu_param #(.DATA_W(8), .NREG(8)) u_dut (
        .CLK            (clk),
        .RESET          (rst),
        .PC             (pc),
        .INSTRUCTION    (instruction),
        .INSTR_BUSYWAIT (instr_busywait),
        .MEM_READ       (mem_read),
        .MEM_WRITE      (mem_write),
        .MEM_ADDRESS    (mem_address),
        .MEM_WRITEDATA  (mem_writedata),
        .MEM_READDATA   (mem_readdata),
        .MEM_BUSYWAIT   (mem_busywait),
        .HALTED         (halted)
    );

    cpu_param #(.DATA_W(16), .NREG(8)) u_dut16 (
        .CLK            (clk),
        .RESET          (rst),
        .PC             (w_pc),
        .INSTRUCTION    (w_instruction),
        .INSTR_BUSYWAIT (w_ibusy),
        .MEM_READ       (w_mrd),
        .MEM_WRITE      (w_mwr),
        .MEM_ADDRESS    (w_addr),
        .MEM_WRITEDATA  (w_wdata),
        .MEM_READDATA   (w_rdata),
        .MEM_BUSYWAIT   (w_mbusy),
        .HALTED         (w_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    endfunction

    // One instruction at the architectural level.
    function automatic void model_exec(input logic [31:0] ins, input logic [7:0] rdata);
        int          op, rd, off, amt;
        logic [7:0]  a, b;
        logic [31:0] nxt;
        op  = int'(ins[31:24]);
        rd  = int'(ins[23:16]) % 8;
        a   = m_reg[int'(ins[15:8]) % 8];
        b   = m_reg[int'(ins[7:0]) % 8];
        amt = int'(ins[7:0]);
        off = int'(ins[23:16]);
        if (off > 127) off -= 256;
        nxt = m_pc + 32'd4;
        case (op)
            'h00: m_reg[rd] = ins[7:0];
            'h01: m_reg[rd] = a;
            'h02: m_reg[rd] = 8'((int'(a) + int'(b)) % 256);
            'h03: m_reg[rd] = 8'((int'(a) - int'(b) + 256) % 256);
            'h04: m_reg[rd] = a & b;
            'h05: m_reg[rd] = a | b;
            'h06: nxt = m_pc + 32'd4 + 32'(off * 4);
            'h07: if (a == b) nxt = m_pc + 32'd4 + 32'(off * 4);
            'h08: if (a != b) nxt = m_pc + 32'd4 + 32'(off * 4);
            'h09, 'h0A: m_reg[rd] = rdata;
            'h0D: m_reg[rd] = (amt >= 8) ? 8'h00 : 8'((int'(a) * (1 << amt)) % 256);
            'h0E: m_reg[rd] = (amt >= 8) ? 8'h00 : 8'(int'(a) / (1 << amt));
            'hFF: nxt = m_pc;
            default: ;
        endcase
        m_pc = nxt;
    endfunction

    // Present one instruction with optional fetch stalls and memory wait states.
    task automatic issue(input logic [31:0] ins, input int ibusy, input int mbusy, input logic [7:0] rdata);
        logic [7:0] op, exp_addr, exp_wdata;
        logic       ld, st;
        int         rd_cycles;
        op        = ins[31:24];
        ld        = (op == 8'h09) || (op == 8'h0A);
        st        = (op == 8'h0B) || (op == 8'h0C);
        exp_addr  = ((op == 8'h09) || (op == 8'h0B)) ? m_reg[int'(ins[7:0]) % 8] : ins[7:0];
        exp_wdata = m_reg[int'(ins[15:8]) % 8];
        for (int i = 0; i < ibusy; i++) begin
            instruction    = $urandom;
            instr_busywait = 1'b1;
            mem_busywait   = 1'($urandom);
            @(posedge clk); #1;
            check("stall_pc", pc, m_pc);
        end
        instruction    = ins;
        instr_busywait = 1'b0;
        mem_busywait   = 1'($urandom);
        #1;
        check("run_no_mem", 32'({mem_read, mem_write}), 32'd0);
        @(posedge clk); #1;
        if (ld || st) begin
            check("mem_pc_hold", pc, m_pc);
            rd_cycles = 0;
            for (int i = 0; i <= mbusy; i++) begin
                mem_busywait   = (i < mbusy);
                mem_readdata   = (i < mbusy) ? 8'($urandom) : rdata;
                instr_busywait = 1'($urandom);
                #1;
                check("mem_read", 32'(mem_read), 32'(ld));
                check("mem_write", 32'(mem_write), 32'(st));
                check("mem_addr", 32'(mem_address), 32'(exp_addr));
                if (st) check("mem_wdata", 32'(mem_writedata), 32'(exp_wdata));
                if (mem_read) rd_cycles++;
                @(posedge clk); #1;
            end
            if (ld) check("read_cycles", 32'(rd_cycles), 32'(mbusy + 1));
            instr_busywait = 1'b0;
            mem_busywait   = 1'b0;
        end
        model_exec(ins, rdata);
        check("pc", pc, m_pc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("reset_pc", pc, 32'h0);
        check("reset_strobes", 32'({mem_read, mem_write, halted}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Store every register (index upper bits randomised) to read it out.
    task automatic dump_regs();
        for (int k = 0; k < 8; k++) begin
            issue({8'h0C, 8'h00, 8'(k + 8 * $urandom_range(0, 31)), 8'($urandom)},
                  0, $urandom_range(0, 1), 8'h00);
        end
    endtask

    task automatic step16(input logic [31:0] ins, input logic [15:0] exp);
        w_instruction = ins;
        w_ibusy       = 1'b0;
        w_mbusy       = 1'b0;
        @(posedge clk); #1;
        if (ins[31:24] == 8'h0C) begin
            check("w16_mem_write", 32'(w_mwr), 32'd1);
            check("w16_wdata", 32'(w_wdata), 32'(exp));
            @(posedge clk); #1;
        end
        w_ibusy = 1'b1;
    endtask

    initial begin
        logic [31:0] ins;
        int          sel;
        rst            = 1'b1;
        instruction    = 32'h0;
        instr_busywait = 1'b1;
        mem_busywait   = 1'b0;
        mem_readdata   = 8'h00;
        w_instruction  = 32'h0;
        w_ibusy        = 1'b1;
        w_mbusy        = 1'b0;
        w_rdata        = 16'h0;
        model_reset();
        #1;
        do_reset();

        // loadi/loadi/sub and the PC sequence
        issue(32'h0001_0005, 0, 0, 8'h00); check("seq_pc_4", pc, 32'h4);
        issue(32'h0002_0003, 1, 0, 8'h00); check("seq_pc_8", pc, 32'h8);
        issue(32'h0303_0102, 0, 0, 8'h00); check("seq_pc_c", pc, 32'hC);
        issue(32'h0C00_0340, 0, 1, 8'h00);

        // beq taken backwards from 0x10, bne not taken
        issue(32'h07FE_0101, 0, 0, 8'h00); check("beq_pc", pc, 32'hC);
        issue(32'h5500_0000, 0, 0, 8'h00); check("nop_pc", pc, 32'h10);
        issue(32'h0805_0101, 0, 0, 8'h00); check("bne_pc", pc, 32'h14);

        // lwd with three wait states
        issue(32'h0005_0020, 0, 0, 8'h00);
        issue(32'h0904_0005, 0, 3, 8'hA5); check("lwd_pc", pc, 32'h1C);
        issue(32'h0C00_0400, 0, 0, 8'h00);

        // sll by an amount >= DATA_W
        issue(32'h0002_007F, 0, 0, 8'h00);
        issue(32'h0D01_0209, 0, 0, 8'h00);
        issue(32'h0C00_0100, 0, 0, 8'h00);

        // asynchronous reset in the middle of a waiting load
        instruction    = 32'h0904_0005;
        instr_busywait = 1'b0;
        @(posedge clk); #1;
        mem_busywait = 1'b1;
        #1;
        check("mid_mem_read", 32'(mem_read), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_read_drop", 32'(mem_read), 32'd0);
        check("async_pc", pc, 32'h0);
        #1 rst = 1'b0;
        mem_busywait = 1'b0;
        model_reset();
        dump_regs();

        // halt at 0x18
        do_reset();
        for (int i = 0; i < 6; i++) issue(32'h2000_0000, 0, 0, 8'h00);
        check("pre_halt_pc", pc, 32'h18);
        issue(32'hFF00_0000, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            instruction    = $urandom;
            instr_busywait = 1'($urandom);
            mem_busywait   = 1'($urandom);
            @(posedge clk); #1;
            check("halt_pc", pc, 32'h18);
            check("halted", 32'({halted, mem_read, mem_write}), 32'b100);
        end
        rst = 1'b1;
        #1;
        check("halt_cleared", 32'(halted), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // random stream against the model
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            sel = $urandom_range(0, 15);
            if (sel < 15) ins[31:24] = 8'(sel);
            else if (ins[31:24] <= 8'h0E || ins[31:24] == 8'hFF) ins[31:24] = 8'h7E;
            issue(ins, $urandom_range(0, 2), $urandom_range(0, 3), 8'($urandom));
        end
        dump_regs();

        // DATA_W=16 instance: sign extension and shifts
        instr_busywait = 1'b1;
        do_reset();
        step16(32'h0001_0080, 16'h0);
        step16(32'h0C00_0100, 16'hFF80);
        step16(32'h0001_00FF, 16'h0);
        step16(32'h0E02_0108, 16'h0);
        step16(32'h0C00_0200, 16'h00FF);
        step16(32'h0D03_0204, 16'h0);
        step16(32'h0C00_0300, 16'h0FF0);
        step16(32'h0D04_0110, 16'h0);
        step16(32'h0C00_0400, 16'h0000);
        step16(32'h0E05_010F, 16'h0);
        step16(32'h0C00_0500, 16'h0001);
        check("w16_pc", w_pc, 32'h2C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cpu_param.md
CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 8: datapath and register width; legal values 8, 16, 32.
REQ-003 Parameter NREG, default 8: register count; power of two, 2..256.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESET  input  1  asynchronous active-high reset.
REQ-006 PC  output  32  address of the current instruction.
REQ-007 INSTRUCTION  input  32  instruction at PC.
REQ-008 INSTR_BUSYWAIT  input  1  instruction not yet valid; the core stalls.
REQ-009 MEM_READ  output  1  data-memory read request.
REQ-010 MEM_WRITE  output  1  data-memory write request.
REQ-011 MEM_ADDRESS  output  DATA_W  data-memory address.
REQ-012 MEM_WRITEDATA  output  DATA_W  store data.
REQ-013 MEM_READDATA  input  DATA_W  load data, valid in the cycle MEM_BUSYWAIT is low.
REQ-014 MEM_BUSYWAIT  input  1  memory busy; the request is held.
REQ-015 HALTED  output  1  high once HALT has executed.

Function
REQ-016 Instruction fields SHALL be: opcode [31:24], rd/branch offset [23:16], rs1 [15:8], rs2/imm [7:0]; register indices use the low log2(NREG) bits, and upper bits are ignored.
REQ-017 Opcodes SHALL be: 00 loadi, 01 mov, 02 add, 03 sub, 04 and, 05 or, 06 j, 07 beq, 08 bne, 09 lwd, 0A lwi, 0B swd, 0C swi, 0D sll, 0E srl, FF halt; any other opcode executes as a NOP (PC+4, no writes).
REQ-018 imm SHALL be sign-extended to DATA_W; arithmetic SHALL be modulo 2^DATA_W; sub computes rs1-rs2.
REQ-019 sll/srl SHALL shift rs1 by imm[7:0] unsigned, and an amount >= DATA_W SHALL yield 0.
REQ-020 The branch/jump target SHALL be PC+4 + (sign-extended offset<<2); beq is taken when rs1==rs2, bne when rs1!=rs2; j is always taken.
REQ-021 The FSM states SHALL be RUN, MEM, HALT.
REQ-022 In RUN with INSTR_BUSYWAIT high, PC, registers and state SHALL hold.
REQ-023 In RUN, ALU/branch/jump instructions SHALL complete in one cycle: rd is written and PC is updated at the same rising edge.
REQ-024 In RUN, a load/store SHALL go to MEM at the next edge, with no PC change.
REQ-025 In MEM: MEM_READ (lwd/lwi) or MEM_WRITE (swd/swi) SHALL be high; MEM_ADDRESS SHALL be rs2 (lwd/swd) or imm (lwi/swi); MEM_WRITEDATA SHALL be rs1; all SHALL be stable while MEM_BUSYWAIT is high.
REQ-026 In MEM, on an edge with MEM_BUSYWAIT low, a load SHALL write MEM_READDATA to rd, PC SHALL advance by 4, and the state SHALL return to RUN; the minimum load/store latency is 2 cycles.
REQ-027 MEM_READ and MEM_WRITE SHALL be low outside MEM and SHALL never both be high.
REQ-028 INSTR_BUSYWAIT SHALL be ignored in MEM.
REQ-029 In HALT, PC and registers SHALL be frozen and HALTED SHALL be high until RESET.
REQ-030 A register read in the same cycle as a write to that register SHALL return the old value.
REQ-031 The design SHALL contain no simulation delays and SHALL be fully synthesizable.

Reset
REQ-032 While RESET is high, the following SHALL be forced immediately, regardless of CLK or state, including mid-MEM: PC=0, all registers=0, state=RUN, MEM_READ=0, MEM_WRITE=0, HALTED=0.
REQ-033 Execution SHALL resume at PC=0 on the first rising edge after RESET falls.

Structure
REQ-034 Package cpu_param_pkg SHALL hold the opcode constants, the state enum and the instruction field bit positions.
REQ-035 Sub-module cpu_param_regfile SHALL implement NREG x DATA_W storage with 2 asynchronous read ports, 1 synchronous write port and asynchronous clear.

Verification (DATA_W=8, NREG=8 unless stated)
REQ-036 loadi r1,05; loadi r2,03; sub r3,r1,r2 -> r3=02; PC sequence 0,4,8,C.
REQ-037 beq r1,r1 with offset FE at PC=10 -> next PC=0C; bne with equal operands -> PC=14.
REQ-038 lwd r4,r5 (r5=20) with MEM_BUSYWAIT high 3 cycles, MEM_READDATA=A5 -> MEM_READ high 4 cycles, MEM_ADDRESS=20, PC held, then r4=A5 and PC+4.
REQ-039 RESET pulsed in MEM during busywait -> MEM_READ drops with no clock edge, PC=0, registers=0.
REQ-040 sll r1,r2,09 -> 00; with DATA_W=16, r2=00FF, sll by 4 -> 0FF0; loadi 80 -> FF80.
REQ-041 halt at PC=18 -> HALTED=1 and PC=18 held for 10 cycles despite INSTRUCTION changes; RESET clears HALTED.
